// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between NREQ requesters.
// Registered one-hot grants, locked multi-beat bursts, one-cycle ack with registered read data.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests (one cycle, no memory access)
// BUSY  | owner holds the port; each cycle with req[owner] high is one beat
module mem_port_arbiter #(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} stateT;

    stateT           state, stateNext;
    logic [OW-1:0]   owner, rrPtr, pickIdx;
    logic [HW-1:0]   holdCnt;
    logic [NREQ-1:0] ownerHot;
    logic            anyReq, othersPending, beat, relNow, found;
    int              idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= '0;
            rrPtr   <= '0;
            holdCnt <= '0;
            gnt     <= '0;
            ack     <= '0;
            rdata   <= '0;
        end else begin
            state <= stateNext;
            ack   <= beat ? ownerHot : '0;
            if (beat && !we[owner])
                rdata <= mem_rdata;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        owner   <= pickIdx;
                        gnt     <= NREQ'(1) << pickIdx;
                        holdCnt <= '0;
                    end
                end
                BUSY: begin
                    // Saturating at MAX_HOLD-1 keeps the cap armed for a late contender after a long lone burst.
                    if (beat && holdCnt != HW'(MAX_HOLD - 1))
                        holdCnt <= holdCnt + 1'b1;
                    if (relNow) begin
                        gnt   <= '0;
                        rrPtr <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pickIdx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                pickIdx = OW'(idx);
            end
        end
        anyReq        = |req;
        ownerHot      = NREQ'(1) << owner;
        othersPending = |(req & ~ownerHot);
        beat          = (state == BUSY) && req[owner];
        relNow        = (state == BUSY) &&
                        (!req[owner] || !lock[owner] ||
                         (holdCnt == HW'(MAX_HOLD - 1) && othersPending));
        stateNext = state;
        case (state)
            IDLE:    if (anyReq) stateNext = BUSY;
            BUSY:    if (relNow) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = beat && we[owner];
        mem_addr  = addr[owner*ADDR_W +: ADDR_W];
        mem_wdata = wdata[owner*DATA_W +: DATA_W];
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a transaction-level reference model and a memory image.
module tb_mem_port_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int MH   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req, we, lock, gnt, ack;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;

    logic [DW-1:0]     mem [0:1023];
    logic              clearMem;

    int                mOwner, mPtr, mBeats;
    logic [NREQ-1:0]   expGnt, expAck;
    logic [DW-1:0]     expRdata;
    logic [DW-1:0]     refMem [0:1023];
    int                nTests, nFail;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock),
        .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mOwner   = -1;
        mPtr     = 0;
        mBeats   = 0;
        expGnt   = '0;
        expAck   = '0;
        expRdata = '0;
    endtask

    // Predicts the effect of the coming clock edge from the current inputs.
    task automatic modelStep();
        int   o, a;
        logic others, done;
        expAck = '0;
        if (mOwner < 0) begin
            done = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                o = (mPtr + k) % NREQ;
                if (!done && req[o]) begin
                    done   = 1'b1;
                    mOwner = o;
                    mBeats = 0;
                    expGnt = 2'(1 << o);
                end
            end
        end else begin
            o = mOwner;
            a = int'(addr[o*AW +: AW]);
            others = (req & ~2'(1 << o)) != 0;
            if (req[o]) begin
                expAck[o] = 1'b1;
                if (we[o]) refMem[a] = wdata[o*DW +: DW];
                else       expRdata  = refMem[a];
            end
            if (!req[o] || !lock[o] || (mBeats + 1 >= MH && others)) begin
                mOwner = -1;
                expGnt = '0;
                mPtr   = (o + 1) % NREQ;
            end
            if (req[o]) mBeats++;
        end
    endtask

    task automatic tick();
        logic beatNow;
        #1;
        beatNow = (mOwner >= 0) && req[mOwner];
        checkVal("gnt", 32'(gnt), 32'(expGnt));
        checkVal("ack", 32'(ack), 32'(expAck));
        checkVal("rdata", rdata, expRdata);
        checkVal("mem_we", 32'(mem_we), 32'(beatNow && we[mOwner]));
        if (beatNow) begin
            checkVal("mem_addr", 32'(mem_addr), 32'(addr[mOwner*AW +: AW]));
            checkVal("mem_wdata", mem_wdata, wdata[mOwner*DW +: DW]);
        end
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setTxn(input int i, input logic w, input logic l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]            = 1'b1;
        we[i]             = w;
        lock[i]           = l;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic burst1(input logic w);
        req = '0;
        lock = '0;
        setTxn(1, w, 1'b1, 10'd0, 32'hC0DE0000);
        tick();
        for (int k = 0; k < 4; k++) begin
            addr[AW +: AW]  = 10'(k);
            wdata[DW +: DW] = 32'hC0DE0000 + 32'(k);
            tick();
        end
        req  = '0;
        lock = '0;
        tick();
        tick();
    endtask

    initial begin
        int   cnt;
        logic sawG1;
        nTests   = 0;
        nFail    = 0;
        clearMem = 1'b1;
        rst_n    = 1'b1;
        req      = 2'b11;
        we       = '0;
        lock     = '0;
        addr     = '0;
        wdata    = '0;
        for (int i = 0; i < 1024; i++) refMem[i] = '0;
        modelReset();
        #1 rst_n = 1'b0;

        repeat (3) begin
            @(negedge clk);
            checkVal("rstGnt", 32'(gnt), 32'h0);
            checkVal("rstAck", 32'(ack), 32'h0);
            checkVal("rstMemWe", 32'(mem_we), 32'h0);
            checkVal("rstRdata", rdata, 32'h0);
        end
        rst_n    = 1'b1;
        clearMem = 1'b0;
        tick();
        checkVal("firstGnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();

        // single write then read-back by requester 0
        setTxn(0, 1'b1, 1'b0, 10'd4, 32'hDEADBEEF);
        tick();
        tick();
        checkVal("wrAck", 32'(ack), 32'h1);
        we[0] = 1'b0;
        tick();
        tick();
        checkVal("rdAck", 32'(ack), 32'h1);
        checkVal("rdData", rdata, 32'hDEADBEEF);
        req = '0;
        tick();

        // both requesting, unlocked: alternating single-beat grants
        setTxn(0, 1'b1, 1'b0, 10'd8, 32'hA5A50008);
        setTxn(1, 1'b0, 1'b0, 10'd8, 32'h0);
        repeat (8) tick();
        req = '0;
        tick();
        tick();

        burst1(1'b1);
        burst1(1'b0);

        // starvation cap: requester 1 joins at requester 0's second beat
        setTxn(0, 1'b1, 1'b1, 10'd30, 32'h55550000);
        tick();
        tick();
        cnt   = 0;
        sawG1 = 1'b0;
        setTxn(1, 1'b0, 1'b0, 10'd4, 32'h0);
        repeat (9) begin
            if (ack[0]) cnt++;
            if (gnt == 2'b10) sawG1 = 1'b1;
            tick();
        end
        checkVal("holdBeats", 32'(cnt), 32'd8);
        checkVal("capGnt1", 32'(sawG1), 32'h1);
        req  = '0;
        lock = '0;
        repeat (3) tick();

        // reset during the third beat of a locked write burst
        setTxn(0, 1'b1, 1'b1, 10'd20, 32'hAAAA0001);
        tick();
        tick();
        addr[0 +: AW] = 10'd21;
        wdata[0 +: DW] = 32'hAAAA0002;
        tick();
        addr[0 +: AW] = 10'd22;
        wdata[0 +: DW] = 32'hAAAA0003;
        #1;
        checkVal("midWe", 32'(mem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        checkVal("midRstGnt", 32'(gnt), 32'h0);
        checkVal("midRstWe", 32'(mem_we), 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkVal("midRstAck", 32'(ack), 32'h0);
        checkVal("mem20", mem[20], 32'hAAAA0001);
        checkVal("mem21", mem[21], 32'hAAAA0002);
        checkVal("mem22", mem[22], 32'h0);
        req  = '0;
        lock = '0;
        modelReset();
        rst_n = 1'b1;
        tick();

        // randomized traffic obeying the hold-until-ack protocol
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom % 3 == 0)
                        setTxn(i, 1'($urandom % 2), ($urandom % 3 == 0), 10'($urandom % 32), $urandom);
                end else if (expAck[i]) begin
                    if ($urandom % 2 == 1)
                        setTxn(i, 1'($urandom % 2), ($urandom % 3 == 0), 10'($urandom % 32), $urandom);
                    else begin
                        req[i]  = 1'b0;
                        lock[i] = 1'b0;
                    end
                end else if ($urandom % 64 == 0) begin
                    req[i]  = 1'b0;
                    lock[i] = 1'b0;
                end
            end
            tick();
        end
        req  = '0;
        lock = '0;
        tick();
        tick();
        for (int a = 0; a < 32; a++) checkVal("memFinal", mem[a], refMem[a]);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
